// File: rtl/apb_pkg.sv
// Shared definitions for the APB command scheduler: default widths, FSM
// state encodings and the layout of a queued command record.
package apb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Command record {wr, addr, data} for the default widths
    localparam int CMD_W        = 1 + ADDR_W_DEF + DATA_W_DEF;
    localparam int CMD_DATA_OFF = 0;
    localparam int CMD_ADDR_OFF = DATA_W_DEF;
    localparam int CMD_WR_OFF   = DATA_W_DEF + ADDR_W_DEF;

    // Record width for arbitrary address/data widths
    function automatic int cmd_width(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Small synchronous command FIFO. Head entry is always visible on dout;
// push while full and pop while empty are ignored.
module apb_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int CMD_W = 17
) (
    input  logic                         clk,
    input  logic                         prst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [CMD_W-1:0]             din,
    output logic [CMD_W-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [CMD_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == {LW{1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign dout      = mem_r[rd_ptr_r];

    // Storage array: write the incoming command at the tail
    always_ff @(posedge clk or posedge prst) begin
        if (prst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {CMD_W{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy
    always_ff @(posedge clk or posedge prst) begin
        if (prst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            level    <= {LW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/apb_cmd_sched.sv
// Command scheduler in front of the APB master: queues requests, launches
// one transfer at a time, waits for completion or timeout and returns a
// response to the requester.
module apb_cmd_sched
    import apb_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                         clk,
    input  logic                         prst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_wr,
    input  logic [ADDR_W-1:0]            cmd_addr,
    input  logic [DATA_W-1:0]            cmd_data,
    output logic                         start,
    output logic                         wr,
    output logic [ADDR_W-1:0]            addr_p,
    output logic [DATA_W-1:0]            data_p,
    input  logic                         xfer_done,
    input  logic [DATA_W-1:0]            rdata_in,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_wr,
    output logic [ADDR_W-1:0]            rsp_addr,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_err,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int CW = cmd_width(ADDR_W, DATA_W);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [1:0]    state_r;
    logic [TW-1:0] timer_r;
    logic [CW-1:0] push_data_s;
    logic [CW-1:0] head_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;

    // No pass-through: readiness depends only on the registered occupancy
    assign cmd_ready   = ~full_s;
    assign push_s      = cmd_valid & ~full_s;
    assign pop_s       = (state_r == ST_IDLE) & ~empty_s;
    assign push_data_s = {cmd_wr, cmd_addr, cmd_data};

    apb_cmd_fifo #(
        .DEPTH (DEPTH),
        .CMD_W (CW)
    ) u_fifo (
        .clk   (clk),
        .prst  (prst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (push_data_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level)
    );

    // Transfer FSM with hold registers, timeout timer and response registers
    always_ff @(posedge clk or posedge prst) begin
        if (prst) begin
            state_r   <= ST_IDLE;
            timer_r   <= {TW{1'b0}};
            start     <= 1'b0;
            wr        <= 1'b0;
            addr_p    <= {ADDR_W{1'b0}};
            data_p    <= {DATA_W{1'b0}};
            rsp_valid <= 1'b0;
            rsp_wr    <= 1'b0;
            rsp_addr  <= {ADDR_W{1'b0}};
            rsp_data  <= {DATA_W{1'b0}};
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!empty_s) begin
                        wr      <= head_s[CW-1];
                        addr_p  <= head_s[DATA_W +: ADDR_W];
                        data_p  <= head_s[DATA_W-1:0];
                        start   <= 1'b1;
                        busy    <= 1'b1;
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    start   <= 1'b0;
                    timer_r <= {TW{1'b0}};
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion takes priority over a timeout in the same cycle
                    if (xfer_done) begin
                        rsp_valid <= 1'b1;
                        rsp_wr    <= wr;
                        rsp_addr  <= addr_p;
                        rsp_data  <= wr ? {DATA_W{1'b0}} : rdata_in;
                        rsp_err   <= 1'b0;
                        state_r   <= ST_RESP;
                    end else if (timer_r == T_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_wr    <= wr;
                        rsp_addr  <= addr_p;
                        rsp_data  <= {DATA_W{1'b0}};
                        rsp_err   <= 1'b1;
                        state_r   <= ST_RESP;
                    end else begin
                        timer_r <= timer_r + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    start     <= 1'b0;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_sched.sv
// Scoreboard bench for apb_cmd_sched: stimulus tasks push expected issues
// and responses into queues; a monitor pops and compares on each start
// pulse and each response handshake.
module tb_apb_cmd_sched;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       prst;
    logic       cmd_valid, cmd_ready, cmd_wr;
    logic [7:0] cmd_addr, cmd_data;
    logic       start, wr;
    logic [7:0] addr_p, data_p;
    logic       xfer_done;
    logic [7:0] rdata_in;
    logic       rsp_valid, rsp_ready, rsp_wr, rsp_err, busy;
    logic [7:0] rsp_addr, rsp_data;
    logic [2:0] level;

    typedef struct packed { logic wr; logic [7:0] addr; logic [7:0] data; } cmd_t;
    typedef struct packed { logic wr; logic [7:0] addr; logic [7:0] data; logic err; } rsp_t;

    cmd_t mq[$];
    cmd_t iq[$];
    rsp_t rq[$];
    int   checks = 0;
    int   errors = 0;
    int   issued_cnt = 0;
    int   xfer_cnt = 0;

    always #5 clk = ~clk;

    apb_cmd_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .prst(prst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .start(start), .wr(wr), .addr_p(addr_p), .data_p(data_p),
        .xfer_done(xfer_done), .rdata_in(rdata_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .level(level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every start pulse and every response handshake
    initial begin : monitor
        logic prev_start;
        cmd_t mc;
        rsp_t mr;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (prst) begin
                prev_start = 1'b0;
            end else begin
                if (start) begin
                    chk("start_one_cycle", {31'd0, prev_start}, 32'd0);
                    if (mq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_start addr_p=0x%0h expected no transfer", addr_p);
                    end else begin
                        mc = mq.pop_front();
                        chk("issue_wr", {31'd0, wr}, {31'd0, mc.wr});
                        chk("issue_addr", {24'd0, addr_p}, {24'd0, mc.addr});
                        if (mc.wr) chk("issue_data", {24'd0, data_p}, {24'd0, mc.data});
                        iq.push_back(mc);
                        issued_cnt++;
                    end
                end
                prev_start = start;
                if (rsp_valid && rsp_ready) begin
                    if (rq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_rsp rsp_addr=0x%0h expected no response", rsp_addr);
                    end else begin
                        mr = rq.pop_front();
                        chk("rsp_wr", {31'd0, rsp_wr}, {31'd0, mr.wr});
                        chk("rsp_addr", {24'd0, rsp_addr}, {24'd0, mr.addr});
                        chk("rsp_data", {24'd0, rsp_data}, {24'd0, mr.data});
                        chk("rsp_err", {31'd0, rsp_err}, {31'd0, mr.err});
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic w, input logic [7:0] a, input logic [7:0] d);
        bit   ok;
        cmd_t c;
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_wr = w; cmd_addr = a; cmd_data = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout addr=0x%0h cmd_ready stuck at 0, expected 1", a);
        end else begin
            c.wr = w; c.addr = a; c.data = d;
            mq.push_back(c);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Completes the oldest issued transfer: done after d WAIT cycles, or timeout
    task automatic do_xfer(input logic [7:0] rd, input int d, input bit tmo);
        bit   ok;
        cmd_t c;
        rsp_t r;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (issued_cnt > xfer_cnt) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL xfer_no_start issued=%0d expected more than %0d", issued_cnt, xfer_cnt);
            return;
        end
        xfer_cnt++;
        c = iq.pop_front();
        r.wr = c.wr; r.addr = c.addr; r.err = tmo;
        r.data = (tmo || c.wr) ? 8'h00 : rd;
        rq.push_back(r);
        @(posedge clk); #1;
        if (tmo) begin
            repeat (TIMEOUT - 1) @(posedge clk);
            #1;
            @(negedge clk);
            chk("no_early_timeout", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
            chk("timeout_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        end else begin
            repeat (d) @(posedge clk);
            #1;
            xfer_done = 1'b1; rdata_in = rd;
            @(posedge clk); #1;
            xfer_done = 1'b0; rdata_in = 8'h00;
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s busy stuck at 1, expected 0", name);
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_start"}, {31'd0, start}, 32'd0);
        chk({tag, "_wr"}, {31'd0, wr}, 32'd0);
        chk({tag, "_addr_p"}, {24'd0, addr_p}, 32'd0);
        chk({tag, "_data_p"}, {24'd0, data_p}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_wr"}, {31'd0, rsp_wr}, 32'd0);
        chk({tag, "_rsp_addr"}, {24'd0, rsp_addr}, 32'd0);
        chk({tag, "_rsp_data"}, {24'd0, rsp_data}, 32'd0);
        chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_level"}, {29'd0, level}, 32'd0);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'h00; cmd_data = 8'h00;
        xfer_done = 1'b0; rdata_in = 8'h00; rsp_ready = 1'b1;
        prst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        prst = 1'b0;
        @(posedge clk); #1;

        // Single write: start one cycle after acceptance
        send_cmd(1'b1, 8'h10, 8'hA5);
        @(negedge clk);
        chk("start_latency_accept_cycle", {31'd0, start}, 32'd0);
        @(negedge clk);
        chk("start_latency_next_cycle", {31'd0, start}, 32'd1);
        #1;
        do_xfer(8'h00, 0, 1'b0);
        wait_idle("idle_after_write");

        // Read with stalled requester: response held stable
        rsp_ready = 1'b0;
        send_cmd(1'b0, 8'h22, 8'h00);
        do_xfer(8'h5C, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_rsp_data", {24'd0, rsp_data}, 32'h5C);
            chk("stall_rsp_addr", {24'd0, rsp_addr}, 32'h22);
            chk("stall_rsp_wr", {31'd0, rsp_wr}, 32'd0);
            chk("stall_rsp_err", {31'd0, rsp_err}, 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_idle("idle_after_stall");

        // Five back-to-back commands with the first transfer outstanding
        send_cmd(1'b1, 8'h40, 8'h11);
        send_cmd(1'b0, 8'h41, 8'h00);
        send_cmd(1'b1, 8'h42, 8'h33);
        send_cmd(1'b0, 8'h43, 8'h00);
        send_cmd(1'b1, 8'h44, 8'h55);
        @(negedge clk);
        chk("full_level", {29'd0, level}, 32'd4);
        chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            do_xfer(8'h90 + 8'(i), 0, 1'b0);
        end
        wait_idle("idle_after_burst");
        chk("drained_level", {29'd0, level}, 32'd0);

        // Timeout, then completion on the last WAIT cycle
        send_cmd(1'b0, 8'h30, 8'h00);
        do_xfer(8'hAB, 0, 1'b1);
        wait_idle("idle_after_timeout");
        send_cmd(1'b0, 8'h31, 8'h00);
        do_xfer(8'hCD, TIMEOUT - 1, 1'b0);
        wait_idle("idle_after_late_done");

        // Reset during WAIT with two commands queued
        send_cmd(1'b1, 8'h50, 8'h01);
        send_cmd(1'b1, 8'h51, 8'h02);
        send_cmd(1'b0, 8'h52, 8'h00);
        @(negedge clk);
        chk("queued_level", {29'd0, level}, 32'd2);
        chk("queued_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #2;
        prst = 1'b1;
        #1;
        chk_reset_state("midreset");
        mq.delete();
        iq.delete();
        xfer_cnt = issued_cnt;
        repeat (2) @(posedge clk);
        #1;
        prst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);
        chk("post_reset_level", {29'd0, level}, 32'd0);
        @(posedge clk); #1;
        send_cmd(1'b0, 8'h60, 8'h00);
        do_xfer(8'h3E, 2, 1'b0);
        wait_idle("idle_after_reset_cmd");

        // xfer_done while IDLE is ignored
        xfer_done = 1'b1; rdata_in = 8'hFF;
        @(posedge clk); #1;
        xfer_done = 1'b0; rdata_in = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("idle_done_busy", {31'd0, busy}, 32'd0);
            chk("idle_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;

        // xfer_done during RESP is ignored
        rsp_ready = 1'b0;
        send_cmd(1'b0, 8'h70, 8'h00);
        do_xfer(8'h77, 0, 1'b0);
        xfer_done = 1'b1; rdata_in = 8'hEE;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("resp_done_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("resp_done_rsp_data", {24'd0, rsp_data}, 32'h77);
        end
        @(posedge clk); #1;
        xfer_done = 1'b0; rdata_in = 8'h00;
        rsp_ready = 1'b1;
        wait_idle("idle_after_resp_done");
        repeat (3) @(negedge clk);
        chk("final_busy", {31'd0, busy}, 32'd0);

        chk("rsp_queue_empty", rq.size(), 32'd0);
        chk("cmd_queue_empty", mq.size(), 32'd0);
        chk("inflight_queue_empty", iq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_cmd_sched.md
Name: apb_cmd_sched

Overview:
- Request scheduler directly upstream of the APB master.
- Accepts a stream of read/write commands over a valid/ready interface and buffers them in a small FIFO.
- Issues commands to the master one at a time: a one-cycle start pulse plus stable wr/addr_p/data_p.
- Waits for transfer completion or timeout, then returns a response (read data / error) to the requester.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, >= 2.
- TIMEOUT, 16, max cycles in WAIT before an error response; >= 2.
- ADDR_W, 8, address width; matches the master's addr_p.
- DATA_W, 8, data width; matches the master's data_p.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- prst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  requester presents a command.
- cmd_ready  out  1  FIFO can accept; equals (level < DEPTH).
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  command address.
- cmd_data  in  DATA_W  write data; ignored for reads.
- start  out  1  one-cycle pulse to the APB master launching a transfer.
- wr  out  1  transfer direction to the master.
- addr_p  out  ADDR_W  transfer address to the master.
- data_p  out  DATA_W  write data to the master.
- xfer_done  in  1  master indicates access phase completed (penable & pready).
- rdata_in  in  DATA_W  read data from the master; valid when xfer_done.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  requester consumes the response.
- rsp_wr  out  1  direction of the responded command.
- rsp_addr  out  ADDR_W  address of the responded command.
- rsp_data  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  1 = transfer timed out.
- busy  out  1  state != IDLE.
- level  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (async, prst=1):
  - FSM -> IDLE; FIFO pointers and level -> 0; timer -> 0.
  - start, wr, addr_p, data_p, rsp_valid, rsp_wr, rsp_addr, rsp_data, rsp_err, busy -> 0.
  - cmd_ready -> 1.
  - Any in-flight or queued command is discarded and no response is produced.
- FIFO:
  - Push on a cycle with cmd_valid & cmd_ready; entry = {cmd_wr, cmd_addr, cmd_data}.
  - Pop only on the IDLE->ISSUE transition.
  - Pointers wrap modulo DEPTH.
  - When full, cmd_ready=0 even if a pop occurs that cycle; there is no pass-through.
  - A simultaneous push and pop leaves level unchanged.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if level != 0, pop the head into hold registers (wr/addr_p/data_p) and go to ISSUE.
  - ISSUE: start=1 for exactly this cycle; timer cleared; go to WAIT.
  - WAIT:
    - If xfer_done: go to RESP with rsp_err=0 and rsp_data = (wr ? 0 : rdata_in).
    - Else, if timer == TIMEOUT-1: go to RESP with rsp_err=1, rsp_data=0.
    - Else, timer increments.
  - RESP: rsp_valid=1, with rsp_wr/rsp_addr taken from the hold registers. Hold all response outputs until rsp_ready=1; on that edge rsp_valid->0 and the state goes to IDLE.
- Output stability:
  - wr/addr_p/data_p are driven from the hold registers and stay stable from ISSUE until the next pop.
- Latency:
  - A command accepted into an empty FIFO at edge k gives start=1 between edges k+1 and k+2.
  - Back-to-back minimum: one transfer per 4 cycles (IDLE, ISSUE, WAIT≥1, RESP with rsp_ready=1).
- Corner cases:
  - xfer_done on the same cycle as the timeout count: done wins, rsp_err=0.
  - xfer_done outside WAIT is ignored.
  - Pushes continue during ISSUE/WAIT/RESP while the FIFO is not full.
- Arithmetic:
  - level counts 0..DEPTH.
  - timer width is $clog2(TIMEOUT) and it never wraps, because the timeout check precedes the increment.

Decomposition:
- Shared package apb_pkg holds:
  - ADDR_W/DATA_W defaults.
  - The state enum (IDLE, ISSUE, WAIT, RESP).
  - The command record width CMD_W = 1+ADDR_W+DATA_W and its field offsets.
- One sub-module, apb_cmd_fifo (parameters DEPTH, CMD_W):
  - Synchronous FIFO with push/pop/full/empty/level and the same async active-high reset.
- FSM, timer and response registers live in apb_cmd_sched.

Test Plan:
- Reset, then single write {wr=1, addr=0x10, data=0xA5} -> start pulses once, one cycle after acceptance, with addr_p=0x10, data_p=0xA5, wr=1. After xfer_done: rsp_valid=1, rsp_wr=1, rsp_addr=0x10, rsp_data=0x00, rsp_err=0.
- Read to addr=0x22 with rdata_in=0x5C on xfer_done -> rsp_data=0x5C, rsp_wr=0, rsp_err=0. rsp_ready held low 3 cycles -> all response outputs stable until it rises.
- Push 5 commands back-to-back with xfer_done withheld, DEPTH=4 -> first is popped, 4 fill the FIFO, cmd_ready=0 and level=4. Completing each transfer -> responses in push order.
- No xfer_done for TIMEOUT=16 cycles after start -> RESP with rsp_err=1, rsp_data=0. xfer_done arriving exactly at cycle 15 of WAIT -> rsp_err=0.
- Assert prst during WAIT with 2 commands queued -> all outputs 0, cmd_ready=1, level=0, no response. After release, a new command issues normally.
- xfer_done pulses while IDLE and during RESP -> no state change and no spurious response.
